mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/arb_pick.sv | 33 +++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  localparam int ADDR_W_DEF    = 8;
  localparam int DATA_W_DEF    = 8;
  localparam int MAX_BURST_DEF = 4;

  // Burst counter width; a single-access burst still needs one bit.
  function automatic int burst_cnt_width(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational 2-way winner select. Ties go round-robin against i_last_owner,
// or always to the CPU when MEM_ARB_FIXED_PRIO_EN is defined.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_owner,
  output logic       o_valid,
  output logic       o_winner
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic w_unused_last_owner;
  assign w_unused_last_owner = i_last_owner;
`endif

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    o_valid  = |i_req;
    o_winner = M_CPU;
    case (i_req)
      2'b01:   o_winner = M_CPU;
      2'b10:   o_winner = M_DMA;
`ifdef MEM_ARB_FIXED_PRIO_EN
      2'b11:   o_winner = M_CPU;
`else
      2'b11:   o_winner = ~i_last_owner;
`endif
      default: o_winner = M_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (CPU / DMA) arbiter for a single memory port with burst fairness and lock.
// Optional MEM_ARB_FIXED_PRIO_EN: CPU wins ties and is never forced off the bus.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] from_memory,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] to_memory,
  output logic              write_en
);

  localparam int               CNT_W      = burst_cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_owner;
  logic              r_last_owner;
  logic [CNT_W-1:0]  r_burst_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rvalid;

  logic              w_pick_valid;
  logic              w_pick_winner;
  logic              w_own_req;
  logic              w_own_we;
  logic              w_own_lock;
  logic [ADDR_W-1:0] w_own_addr;
  logic [DATA_W-1:0] w_own_wdata;
  logic              w_other_req;
  logic              w_granted;
  logic              w_accept;
  logic              w_force_ok;
  logic              w_release;

  arb_pick u_pick (
    .i_req        ({m1_req, m0_req}),
    .i_last_owner (r_last_owner),
    .o_valid      (w_pick_valid),
    .o_winner     (w_pick_winner)
  );

  always_comb begin
    if (r_owner == M_DMA) begin
      w_own_req   = m1_req;
      w_own_we    = m1_we;
      w_own_lock  = m1_lock;
      w_own_addr  = m1_addr;
      w_own_wdata = m1_wdata;
      w_other_req = m0_req;
    end else begin
      w_own_req   = m0_req;
      w_own_we    = m0_we;
      w_own_lock  = m0_lock;
      w_own_addr  = m0_addr;
      w_own_wdata = m0_wdata;
      w_other_req = m1_req;
    end
  end

  assign w_granted = (r_state == ARB_GRANT);
  assign w_accept  = w_granted & w_own_req;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign w_force_ok = (r_owner == M_DMA);
`else
  assign w_force_ok = 1'b1;
`endif

  // Fairness release fires on the last allowed access, only if the other side waits.
  assign w_release = w_granted &
                     (~w_own_req |
                      (w_accept & (r_burst_cnt == BURST_LAST) & w_other_req &
                       ~w_own_lock & w_force_ok));

  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE:  if (w_pick_valid) w_state_nxt = ARB_GRANT;
      ARB_GRANT: if (w_release)    w_state_nxt = ARB_IDLE;
      default:                     w_state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    address   = '0;
    to_memory = '0;
    write_en  = 1'b0;
    if (w_granted) begin
      m0_gnt    = (r_owner == M_CPU);
      m1_gnt    = (r_owner == M_DMA);
      address   = w_own_addr;
      to_memory = w_own_wdata;
      write_en  = w_own_req & w_own_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= M_CPU;
      r_last_owner <= M_DMA;
      r_burst_cnt  <= '0;
      r_rdata      <= '0;
      r_rvalid     <= '0;
    end else begin
      r_rvalid <= '0;
      if ((r_state == ARB_IDLE) && w_pick_valid) begin
        r_owner     <= w_pick_winner;
        r_burst_cnt <= '0;
      end
      if (w_accept) begin
        if (r_burst_cnt != BURST_LAST) r_burst_cnt <= r_burst_cnt + CNT_W'(1);
        if (!w_own_we) begin
          r_rdata           <= from_memory;
          r_rvalid[r_owner] <= 1'b1;
        end
      end
      if (w_release) r_last_owner <= r_owner;
    end
  end

  assign rdata     = r_rdata;
  assign m0_rvalid = r_rvalid[M_CPU];
  assign m1_rvalid = r_rvalid[M_DMA];

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// against a tenure-level reference model. Honours MEM_ARB_FIXED_PRIO_EN.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req = '0;
  logic [1:0]    we = '0;
  logic [1:0]    lock = '0;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];

  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, write_en;
  logic [DW-1:0] rdata, from_memory, to_memory;
  logic [AW-1:0] address;

  logic [DW-1:0] tb_mem  [256];
  logic [DW-1:0] ref_mem [256];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_a = '0;
  logic [DW-1:0] ld_d = '0;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: owner -1 means the bus is idle.
  int         mo_own;
  int         mo_last;
  int         mo_cnt;
  logic [1:0] mo_rv;
  logic [7:0] mo_rd;
  logic [1:0] mo_acc;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .m0_req      (req[0]),
    .m0_we       (we[0]),
    .m0_lock     (lock[0]),
    .m0_addr     (addr[0]),
    .m0_wdata    (wdata[0]),
    .m0_gnt      (m0_gnt),
    .m0_rvalid   (m0_rvalid),
    .m1_req      (req[1]),
    .m1_we       (we[1]),
    .m1_lock     (lock[1]),
    .m1_addr     (addr[1]),
    .m1_wdata    (wdata[1]),
    .m1_gnt      (m1_gnt),
    .m1_rvalid   (m1_rvalid),
    .rdata       (rdata),
    .from_memory (from_memory),
    .address     (address),
    .to_memory   (to_memory),
    .write_en    (write_en)
  );

  assign from_memory = tb_mem[address];

  always @(posedge clk) begin
    if (ld_en)         tb_mem[ld_a]    <= ld_d;
    else if (write_en) tb_mem[address] <= to_memory;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [1:0] r, input int last);
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
`ifdef MEM_ARB_FIXED_PRIO_EN
    return (last >= 0) ? 0 : 0;
`else
    return 1 - last;
`endif
  endfunction

  task automatic model_reset();
    mo_own  = -1;
    mo_last = 1;
    mo_cnt  = 0;
    mo_rv   = '0;
    mo_rd   = '0;
    mo_acc  = '0;
  endtask

  // One clock: compare outputs mid-cycle, advance the model at the edge, return at edge+1.
  task automatic step();
    logic [1:0] e_gnt;
    logic       e_we;
    logic       own_req;
    logic       may_force;
    logic [7:0] e_addr, e_wd;
    @(negedge clk);
    e_gnt = '0; e_we = 1'b0; e_addr = '0; e_wd = '0; own_req = 1'b0;
    if (mo_own >= 0) begin
      e_gnt[mo_own] = 1'b1;
      e_addr  = addr[mo_own];
      e_wd    = wdata[mo_own];
      own_req = req[mo_own];
      e_we    = own_req & we[mo_own];
    end
    check("gnt",       32'({m1_gnt, m0_gnt}),       32'(e_gnt));
    check("rvalid",    32'({m1_rvalid, m0_rvalid}), 32'(mo_rv));
    check("rdata",     32'(rdata),                  32'(mo_rd));
    check("write_en",  32'(write_en),               32'(e_we));
    check("address",   32'(address),                32'(e_addr));
    check("to_memory", 32'(to_memory),              32'(e_wd));
    @(posedge clk);
    mo_acc = '0;
    if (rst) begin
      if (e_we) ref_mem[e_addr] = e_wd;
      model_reset();
    end else if (mo_own < 0) begin
      mo_rv = '0;
      if (|req) begin
        mo_own = pick(req, mo_last);
        mo_cnt = 0;
      end
    end else if (!own_req) begin
      mo_rv   = '0;
      mo_last = mo_own;
      mo_own  = -1;
    end else begin
      mo_acc[mo_own] = 1'b1;
      mo_rv = '0;
      if (e_we) ref_mem[e_addr] = e_wd;
      else begin
        mo_rd = ref_mem[e_addr];
        mo_rv[mo_own] = 1'b1;
      end
`ifdef MEM_ARB_FIXED_PRIO_EN
      may_force = (mo_own == 1);
`else
      may_force = 1'b1;
`endif
      if (mo_cnt == MB - 1 && req[1 - mo_own] && !lock[mo_own] && may_force) begin
        mo_last = mo_own;
        mo_own  = -1;
      end
      if (mo_cnt < MB - 1) mo_cnt++;
    end
    #1;
  endtask

  task automatic randomize_inputs();
    for (int m = 0; m < 2; m++) begin
      if (!req[m] || mo_acc[m]) begin
        req[m]   = ($urandom_range(0, 3) != 0);
        we[m]    = 1'($urandom_range(0, 1));
        addr[m]  = 8'($urandom_range(0, 63));
        wdata[m] = 8'($urandom);
      end
      lock[m] = ($urandom_range(0, 5) == 0);
    end
    rst = ($urandom_range(0, 199) == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int t;
    logic [1:0] exp_g;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;

    // Reset; preload memory (writes through the bench port only while the arbiter is held)
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ld_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ld_a = 8'(i);
      ld_d = (i == 8'h10) ? 8'hA5 : 8'($urandom);
      ref_mem[i] = ld_d;
      @(posedge clk);
      #1;
    end
    ld_en = 1'b0;
    model_reset();
    check("reset_outputs",
          32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, write_en, rdata, address, to_memory}), 32'd0);
    rst = 1'b0;
    repeat (5) step();
    check("idle_outputs",
          32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, write_en, rdata, address, to_memory}), 32'd0);

    // CPU read alone
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'h10;
    step();
    check("cpu_read_gnt", 32'({m1_gnt, m0_gnt}), 32'd1);
    step();
    req[0] = 1'b0;
    check("cpu_read_rdata",  32'(rdata), 32'hA5);
    check("cpu_read_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd1);
    repeat (3) step();

    // Both requesting from reset: grant pattern
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 2'b11; we = 2'b00; addr[0] = 8'h30; addr[1] = 8'h31;
    for (k = 0; k < 30; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_g = (k == 0) ? 2'b00 : 2'b01;
`else
      if (k == 0) exp_g = 2'b00;
      else begin
        t = (k - 1) % 10;
        exp_g = (t < 4) ? 2'b01 : (t == 4 || t == 9) ? 2'b00 : 2'b10;
      end
`endif
      check("rr_pattern", 32'({m1_gnt, m0_gnt}), 32'(exp_g));
      step();
    end
    req[0] = 1'b0;
    t = 0;
    while (!m1_gnt && t < 4) begin
      step();
      t++;
    end
    check("dma_after_cpu_drop", 32'(m1_gnt), 32'd1);
    req = 2'b00;
    repeat (3) step();

    // Locked DMA write burst while the CPU waits
    req[1] = 1'b1; lock[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'h20; wdata[1] = 8'h01;
    step();
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'h10;
    for (int i = 0; i < 6; i++) begin
      addr[1]  = 8'(8'h20 + i);
      wdata[1] = 8'(i + 1);
      check("lock_gnt", 32'({m1_gnt, m0_gnt}), 32'd2);
      check("lock_we",  32'(write_en), 32'd1);
      step();
    end
    req[1] = 1'b0; lock[1] = 1'b0;
    step();
    step();
    check("cpu_after_dma", 32'({m1_gnt, m0_gnt}), 32'd1);
    req[0] = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 6; i++) check("lock_mem", 32'(tb_mem[8'h20 + i]), 32'(i + 1));

    // Reset in the middle of a DMA write burst
    req[1] = 1'b1; lock[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'h40; wdata[1] = 8'h77;
    step();
    step();
    check("pre_rst_we", 32'(write_en), 32'd1);
    rst = 1'b1;
    step();
    check("rst_mid_we",     32'(write_en), 32'd0);
    check("rst_mid_gnt",    32'({m1_gnt, m0_gnt}), 32'd0);
    check("rst_mid_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
    rst = 1'b0;
    req = 2'b11; we = 2'b00; lock = 2'b00; addr[0] = 8'h11; addr[1] = 8'h12;
    step();
    check("post_rst_tie", 32'({m1_gnt, m0_gnt}), 32'd1);
    req = 2'b00;
    repeat (3) step();

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      randomize_inputs();
      step();
    end
    rst = 1'b0; req = 2'b00;
    repeat (6) step();
    for (int i = 0; i < 64; i++) check("mem_final", 32'(tb_mem[i]), 32'(ref_mem[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
